wino_output_accumulator: RTL and testbench
==========================================

// Module: wino_output_accumulator
// PURPOSE
//  Sits directly downstream of the Winograd PE output port (result tile/address/valid).
//  Sums each output tile over all input-depth (ID) channels and emits the finished tile once.
//  Holds one partial-sum entry per result address.
//  Saturates the finished tile and emits it on a valid/ready port to the output writer.
//  A small control FSM tracks a layer from cfg_start_i until all expected tiles are emitted.
// PARAMETERS
//  DEPTH   256  partial-sum entries; result addresses at or above DEPTH are out of range
//  IN_W    12   signed width of each incoming PE result element
//  ACC_W   20   signed accumulator width per element
//  OUT_W   16   signed width of each emitted (saturated) element
// PORTS
//  clk               in   1                 clock, rising edge
//  reset_n           in   1                 synchronous, active-low reset
//  cfg_start_i       in   1                 pulse: latch config, clear all entries, enter RUN
//  cfg_num_ch_i      in   5                 ID channels summed per tile (0 is treated as 1)
//  cfg_num_tiles_i   in   16                finished tiles expected this layer
//  result_tile_i     in   [0:5][0:5]xIN_W   PE result tile, signed
//  result_valid_i    in   1                 tile valid; no backpressure toward the PE
//  result_address_i  in   8                 partial-sum entry index
//  size_type_i       in   1                 0 = 6x6 tile; 1 = 4x4 tile (rows/cols 4,5 forced to 0)
//  out_tile_o        out  [0:5][0:5]xOUT_W  finished tile, registered
//  out_address_o     out  8                 address of the finished tile
//  out_valid_o       out  1                 finished tile valid
//  out_ready_i       in   1                 downstream accept
//  busy_o            out  1                 high in RUN
//  done_o            out  1                 1-cycle pulse, in DONE state
//  overflow_o        out  1                 sticky error flag; cleared by reset or cfg_start_i
// BEHAVIOUR
//  Reset
//   - All outputs and entry counters are 0; FSM is IDLE.
//   - Accumulator contents are don't-care, because a counter of 0 marks the entry empty.
//  FSM
//   - IDLE -> RUN on cfg_start_i.
//   - RUN -> DONE in the cycle the emitted count reaches cfg_num_tiles_i.
//   - DONE -> IDLE after 1 cycle.
//   - cfg_start_i in any state clears all counters, out_valid_o, the emitted count and overflow_o,
//     relatches the config and enters RUN (restart).
//   - cfg_num_tiles_i = 0: the FSM goes RUN -> DONE on the next cycle.
//  Accumulate (RUN and result_valid_i)
//   - a = result_address_i.
//   - acc[a] <= (cnt[a]==0 ? 0 : acc[a]) + sign_ext(tile); cnt[a] <= cnt[a] + 1.
//   - Read-modify-write is single-cycle: a back-to-back hit on the same address must see the
//     previous update (write-first). No stall, no lost sample.
//  Completion
//   - When cnt[a]+1 == num_ch, the summed tile is saturated to OUT_W, each element clamped to
//     [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - It is loaded into the output register with out_address_o = a.
//   - The entry is cleared (cnt[a] <= 0) and the emitted count is incremented.
//   - Latency: final input sampled at edge N gives out_valid_o = 1 after edge N.
//  Output handshake
//   - out_tile_o and out_address_o are held stable while out_valid_o && !out_ready_i.
//   - Transfer happens when out_valid_o && out_ready_i.
//   - A completion in the same cycle as a transfer loads the new tile; out_valid_o stays 1.
//   - A completion while out_valid_o && !out_ready_i drops the new tile, sets overflow_o and
//     still clears the entry and counts it as emitted.
//  Ignored inputs
//   - result_valid_i outside RUN is ignored.
//   - An address >= DEPTH is ignored and sets overflow_o.
//  Arithmetic
//   - Accumulation wraps at ACC_W; only the final output saturates.
//   - size_type_i is sampled per input; rows/cols 4,5 are zeroed before accumulation when it is 1.
// TESTING
//  1. cfg num_ch=3, tiles=1. Three tiles of all +5 at addr 7, out_ready_i=1
//     -> one out_valid_o pulse, addr 7, all elements 15; then done_o pulses; busy_o falls.
//  2. Interleave addr 1/2/1/2 with num_ch=2, values 10/20/-4/1
//     -> out tile 6 at addr 1, then 21 at addr 2, in order, 1 cycle after each final input.
//  3. num_ch=2. Two tiles of all +2047 (IN_W max) per addr, twice (OUT_W=12 build)
//     -> all elements clamp to 2047. Negative case -2048 x2 -> -2048.
//  4. out_ready_i=0 while two addresses complete
//     -> first tile held stable, second dropped, overflow_o=1, emitted count=2, DONE reached.
//  5. size_type_i=1, inputs nonzero everywhere -> out rows/cols 4,5 == 0.
//  6. cfg_start_i mid-accumulation (addr 3 has 1 of 2), then restart with two fresh tiles
//     -> sum excludes the pre-restart tile; overflow_o cleared.
//  7. reset_n low mid-RUN -> next cycle all outputs 0, IDLE; post-reset inputs ignored.

Source files
------------

// File: rtl/wino_output_accumulator.sv
// Per-address partial-sum accumulator for Winograd PE result tiles.
// Sums tiles over the input-depth channels, saturates each finished tile and emits it on a valid/ready port.
module wino_output_accumulator #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IN_W  = 12,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned OUT_W = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cfg_start_i,
   input  logic [4:0]                    cfg_num_ch_i,
   input  logic [15:0]                   cfg_num_tiles_i,
   input  logic [0:5][0:5][IN_W-1:0]     result_tile_i,
   input  logic                          result_valid_i,
   input  logic [7:0]                    result_address_i,
   input  logic                          size_type_i,
   output logic [0:5][0:5][OUT_W-1:0]    out_tile_o,
   output logic [7:0]                    out_address_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          overflow_o
);

   localparam int unsigned CW = 5;
   localparam int unsigned TW = 16;
   localparam int unsigned AW = 8;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'(1) << (OUT_W - 1)) - 64'(1));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e                        state_q, state_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          out_valid_q, out_valid_d;
   logic                          overflow_q, overflow_d;
   logic [AW-1:0]                 out_addr_q, out_addr_d;
   logic [0:5][0:5][OUT_W-1:0]    out_tile_q, out_tile_d;
   logic [CW-1:0]                 num_ch_q, num_ch_d;
   logic [TW-1:0]                 num_tiles_q, num_tiles_d;
   logic [TW-1:0]                 emit_q, emit_d;

   logic [CW-1:0]                 cnt_q [DEPTH];
   logic [0:5][0:5][ACC_W-1:0]    acc_q [DEPTH];

   logic [CW-1:0]                 rd_cnt, cnt_inc, cnt_wr;
   logic [0:5][0:5][ACC_W-1:0]    rd_acc, sum;
   logic [0:5][0:5][OUT_W-1:0]    sum_sat;
   logic                          addr_ok, in_fire, acc_we, complete, stall, xfer;

   function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = $signed(v);
      if (s > SAT_MAX)      return OUT_W'(SAT_MAX);
      else if (s < SAT_MIN) return OUT_W'(SAT_MIN);
      else                  return OUT_W'(v);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a start request restarts the layer from any state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cfg_start_i) state_d = S_RUN;
         S_RUN:   if (emit_q == num_tiles_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (cfg_start_i) state_d = S_RUN;
   end

   // Status outputs follow the next state so they are registered alongside it
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_d == S_RUN)  busy_d = 1'b1;
      if (state_d == S_DONE) done_d = 1'b1;
   end

   // Accumulate, complete and handshake datapath
   always_comb begin
      rd_cnt      = cnt_q[result_address_i];
      rd_acc      = acc_q[result_address_i];
      addr_ok     = 32'(result_address_i) < DEPTH;
      in_fire     = (state_q == S_RUN) && result_valid_i && !cfg_start_i;
      acc_we      = in_fire && addr_ok;
      cnt_inc     = rd_cnt + CW'(1);
      complete    = acc_we && (cnt_inc == num_ch_q);
      cnt_wr      = complete ? '0 : cnt_inc;
      xfer        = out_valid_q && out_ready_i;
      stall       = out_valid_q && !out_ready_i;

      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 6; c++) begin
            sum[r][c] = ((rd_cnt == '0) ? '0 : rd_acc[r][c])
                      + ((size_type_i && (r >= 4 || c >= 4)) ? '0
                         : ACC_W'($signed(result_tile_i[r][c])));
            sum_sat[r][c] = sat(sum[r][c]);
         end
      end

      out_valid_d = out_valid_q && !xfer;
      out_addr_d  = out_addr_q;
      out_tile_d  = out_tile_q;
      overflow_d  = overflow_q;
      emit_d      = emit_q;
      num_ch_d    = num_ch_q;
      num_tiles_d = num_tiles_q;

      if (complete) begin
         emit_d = emit_q + TW'(1);
         if (stall) begin
            overflow_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_addr_d  = result_address_i;
            out_tile_d  = sum_sat;
         end
      end
      if (in_fire && !addr_ok) overflow_d = 1'b1;

      if (cfg_start_i) begin
         num_ch_d    = (cfg_num_ch_i == '0) ? CW'(1) : cfg_num_ch_i;
         num_tiles_d = cfg_num_tiles_i;
         emit_d      = '0;
         overflow_d  = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         out_addr_q  <= '0;
         out_tile_q  <= '0;
         num_ch_q    <= CW'(1);
         num_tiles_q <= '0;
         emit_q      <= '0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         out_addr_q  <= out_addr_d;
         out_tile_q  <= out_tile_d;
         num_ch_q    <= num_ch_d;
         num_tiles_q <= num_tiles_d;
         emit_q      <= emit_d;
      end
   end

   // A zero count marks an entry empty, so only the counters need clearing
   always_ff @(posedge clk) begin
      if (!reset_n || cfg_start_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
      end else if (acc_we) begin
         cnt_q[result_address_i] <= cnt_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_we) acc_q[result_address_i] <= sum;
   end

   assign out_tile_o    = out_tile_q;
   assign out_address_o = out_addr_q;
   assign out_valid_o   = out_valid_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_wino_output_accumulator.sv
// Scoreboard bench for wino_output_accumulator (OUT_W=12 build so saturation is reachable).
module tb_wino_output_accumulator;

   typedef logic [0:5][0:5][11:0] tile_t;
   typedef struct {
      logic [7:0] addr;
      tile_t      tile;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_start_i;
   logic [4:0]  cfg_num_ch_i;
   logic [15:0] cfg_num_tiles_i;
   tile_t       result_tile_i;
   logic        result_valid_i;
   logic [7:0]  result_address_i;
   logic        size_type_i;
   tile_t       out_tile_o;
   logic [7:0]  out_address_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        busy_o;
   logic        done_o;
   logic        overflow_o;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   wino_output_accumulator #(
      .DEPTH(256), .IN_W(12), .ACC_W(20), .OUT_W(12)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .cfg_start_i      (cfg_start_i),
      .cfg_num_ch_i     (cfg_num_ch_i),
      .cfg_num_tiles_i  (cfg_num_tiles_i),
      .result_tile_i    (result_tile_i),
      .result_valid_i   (result_valid_i),
      .result_address_i (result_address_i),
      .size_type_i      (size_type_i),
      .out_tile_o       (out_tile_o),
      .out_address_o    (out_address_o),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .overflow_o       (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic tile_t mk(input int inner, input int outer);
      tile_t t;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            t[r][c] = (r < 4 && c < 4) ? 12'(inner) : 12'(outer);
      return t;
   endfunction

   function automatic exp_t ex(input int a, input int inner, input int outer);
      exp_t e;
      e.addr = 8'(a);
      e.tile = mk(inner, outer);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int ch, input int tiles);
      cfg_start_i     = 1'b1;
      cfg_num_ch_i    = 5'(ch);
      cfg_num_tiles_i = 16'(tiles);
      step();
      cfg_start_i     = 1'b0;
   endtask

   task automatic send(input int a, input int v, input bit st);
      result_valid_i   = 1'b1;
      result_address_i = 8'(a);
      size_type_i      = st;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            result_tile_i[r][c] = 12'(v);
      step();
   endtask

   task automatic idle();
      result_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (done_o) begin
            got = 1;
            break;
         end
         step();
      end
      check(nm, got, 1);
   endtask

   // Monitor: every accepted output is matched against the head of the scoreboard
   always @(negedge clk) begin
      if (reset_n && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got addr %0d with empty queue", out_address_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_addr", out_address_o, e.addr);
            check("sb_tile", out_tile_o, e.tile);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; cfg_start_i = 1'b0; cfg_num_ch_i = '0; cfg_num_tiles_i = '0;
      result_tile_i = '0; result_valid_i = 1'b0; result_address_i = '0;
      size_type_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) step();
      check("rst_valid", out_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_addr", out_address_o, 0);
      check("rst_tile", out_tile_o, 0);
      reset_n = 1'b1;
      step();

      // 1: three +5 tiles at addr 7
      start(3, 1);
      check("t1_busy", busy_o, 1);
      exp_q.push_back(ex(7, 15, 15));
      send(7, 5, 0); send(7, 5, 0); send(7, 5, 0);
      idle();
      check("t1_latency", {out_valid_o, out_address_o}, {1'b1, 8'd7});
      wait_done("t1_done");
      step();
      check("t1_done_pulse", done_o, 0);
      check("t1_busy_fall", busy_o, 0);

      // inputs in IDLE produce nothing
      send(5, 9, 0); idle(); step();
      check("idle_ignore", out_valid_o, 0);

      // 2: interleaved addresses, back-to-back completions
      start(2, 2);
      exp_q.push_back(ex(1, 6, 6));
      exp_q.push_back(ex(2, 21, 21));
      send(1, 10, 0); send(2, 20, 0); send(1, -4, 0);
      check("t2_first", {out_valid_o, out_address_o}, {1'b1, 8'd1});
      send(2, 1, 0);
      idle();
      check("t2_second", {out_valid_o, out_address_o}, {1'b1, 8'd2});
      wait_done("t2_done");

      // 3: saturation at OUT_W=12
      start(2, 3);
      exp_q.push_back(ex(10, 2047, 2047));
      exp_q.push_back(ex(11, -2048, -2048));
      exp_q.push_back(ex(12, -1, -1));
      send(10, 2047, 0); send(10, 2047, 0);
      send(11, -2048, 0); send(11, -2048, 0);
      send(12, 2047, 0); send(12, -2048, 0);
      idle();
      wait_done("t3_done");

      // 5: 4x4 masking, sampled per input
      start(2, 2);
      exp_q.push_back(ex(20, 6, 3));
      exp_q.push_back(ex(21, 10, 0));
      send(20, 3, 1); send(20, 3, 0);
      send(21, 5, 1); send(21, 5, 1);
      idle();
      wait_done("t5_done");

      // 4: backpressure drops the second finished tile
      start(1, 2);
      out_ready_i = 1'b0;
      exp_q.push_back(ex(30, 7, 7));
      send(30, 7, 0);
      check("t4_first", {out_valid_o, out_address_o}, {1'b1, 8'd30});
      send(31, 9, 0);
      idle();
      check("t4_ovf", overflow_o, 1);
      check("t4_hold_addr", out_address_o, 30);
      check("t4_hold_tile", out_tile_o, mk(7, 7));
      wait_done("t4_done");
      out_ready_i = 1'b1;
      step();
      check("t4_ovf_sticky", overflow_o, 1);
      check("t4_drained", out_valid_o, 0);

      // zero tiles: DONE right after RUN
      start(1, 0);
      check("t0_busy", busy_o, 1);
      check("t0_ovf_clear", overflow_o, 0);
      step();
      check("t0_done", done_o, 1);

      // 6: restart mid-accumulation discards the partial sum
      start(2, 1);
      send(3, 100, 0);
      idle();
      start(2, 1);
      exp_q.push_back(ex(3, 5, 5));
      send(3, 2, 0); send(3, 3, 0);
      idle();
      check("t6_out", {out_valid_o, out_address_o}, {1'b1, 8'd3});
      check("t6_ovf", overflow_o, 0);
      wait_done("t6_done");

      // 7: reset in the middle of a run
      start(1, 3);
      out_ready_i = 1'b0;
      send(50, 4, 0);
      check("t7_pre", {out_valid_o, busy_o}, 2'b11);
      reset_n = 1'b0;
      send(51, 4, 0);
      check("t7_valid", out_valid_o, 0);
      check("t7_busy", busy_o, 0);
      check("t7_addr", out_address_o, 0);
      check("t7_tile", out_tile_o, 0);
      reset_n = 1'b1;
      out_ready_i = 1'b1;
      send(52, 1, 0);
      idle();
      step();
      check("t7_ignore", {out_valid_o, busy_o}, 2'b00);

      repeat (3) step();
      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
